fb_arbiter: RTL
===============

Name: fb_arbiter

Overview:
- Owns the 1024-byte OLED framebuffer: 8 pages × 128 columns, one byte per page-column.
- Shares the single-port buffer between two requesters. The SPI display streamer is the reader and always has priority. Game/render logic is the writer, using a valid/ready handshake.
- Provides a hardware clear sequencer and a frame-boundary pulse so game logic can time its updates against the display refresh.

Parameters:
- ADDR_W, 10, framebuffer address width (depth = 2**ADDR_W = 1024)
- DATA_W, 8, byte width (one vertical 8-pixel strip)
- COL_BITS, 7, low bits of spi_col used in the address (128 columns)
- CLEAR_VALUE, 8'h00, byte written to every location by the clear sequence

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous assert, active-low
- spi_row  in  3  page index currently requested by the SPI streamer
- spi_col  in  10  column index from the SPI streamer; only [COL_BITS-1:0] used
- spi_data  out  8  registered framebuffer byte for the current reader address
- wr_valid  in  1  writer request
- wr_ready  out  1  writer grant; a write happens when wr_valid && wr_ready
- wr_addr  in  10  write address {page[2:0], col[6:0]}
- wr_data  in  8  write byte
- clr_start  in  1  single-cycle request to clear the whole framebuffer
- clr_busy  out  1  high while the clear sequence runs
- frame_done  out  1  one-cycle pulse when the reader wraps from address 1023 to address 0

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - spi_data = 0, clr_busy = 0, frame_done = 0, state = IDLE.
  - Internal: last_valid = 0, rd_slot = 0, clr_ptr = 0.
  - Memory contents are not reset.
- Reader address: rd_addr = {spi_row, spi_col[COL_BITS-1:0]}; spi_col[9:7] are ignored.
- Read sampling and latency:
  - Every cycle, rd_addr is compared with last_addr. If they differ, or last_valid = 0, rd_slot is registered high for the next cycle and last_addr/last_valid are updated.
  - In a cycle with rd_slot = 1, the RAM is read at last_addr.
  - spi_data updates on the following edge.
  - Total latency is 2 cycles from address change to spi_data. spi_data holds its value until the next read.
- Reader address stability:
  - The reader address must be stable for at least 2 cycles.
  - If it changes every cycle, every cycle becomes a read slot and the writer and clear sequence starve. This is legal; no data is lost, only delayed.
- frame_done: registered one-cycle pulse, asserted together with the spi_data update of a read to address 0 whose previous served address was 1023.
- State machine, IDLE ↔ CLEAR:
  - IDLE → CLEAR on clr_start. clr_ptr is set to 0 and clr_busy goes high on the next edge.
  - CLEAR: in each cycle without rd_slot, write CLEAR_VALUE at clr_ptr, then clr_ptr++.
  - After writing 1023, go to IDLE and drop clr_busy on the same edge.
  - A clear with no reads takes exactly 1024 cycles.
  - clr_start while in CLEAR is ignored.
- Writer grant: wr_ready = (state == IDLE) && !rd_slot && !clr_start, combinational.
  - A granted write commits at the clock edge.
  - If clr_start and wr_valid arrive in the same cycle, the clear wins and the write is not accepted.
  - The writer must hold wr_valid, wr_addr and wr_data until granted.
- Same-address conflicts: the read slot and the write slot never coincide. A read observes every write committed in an earlier cycle.
- Reset mid-clear: return immediately to IDLE with clr_busy = 0. Buffer contents are partially cleared and undefined.

Decomposition:
- display_pkg:
  - FB_DEPTH = 1024, FB_PAGES = 8, FB_COLS = 128.
  - arb_state_t enum {IDLE, CLEAR}.
  - Function fb_addr(page, col) returning {page, col[6:0]}.
- Sub-module fb_ram_sp: single-port 1024×8 synchronous-read RAM with en, we, addr, wdata, rdata. fb_arbiter drives its single address/enable mux.

Test Plan:
- Write then read back: write 8'hA5 to address 0x105 with no reader activity (wr_ready = 1, accepted in 1 cycle). Set spi_row = 2, spi_col = 5 → spi_data = 8'hA5 exactly 2 cycles later.
- Read priority: drive wr_valid continuously and change the reader address every 8 cycles → wr_ready = 0 exactly in each rd_slot cycle, writes resume the next cycle, spi_data is correct for every address.
- Clear: preload bytes, pulse clr_start with wr_valid also high → the write is not accepted, clr_busy is high for 1024 cycles when no reads occur, then every address reads 8'h00. A second clr_start mid-clear does not extend clr_busy.
- Frame wrap: sweep the reader over 0..1023 and then to 0 → exactly one frame_done pulse, coincident with the spi_data update for address 0. No pulse on the first read after reset.
- Reset mid-clear: assert rst_n = 0 asynchronously at clr_ptr = 300 → clr_busy = 0, spi_data = 0 and state = IDLE without waiting for a clock. After release, wr_ready rises on the first non-read cycle.

Source files
------------

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - framebuffer geometry, arbiter state type and address helper
package display_pkg;

  localparam int FB_DEPTH = 1024;
  localparam int FB_PAGES = 8;
  localparam int FB_COLS  = 128;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } arb_state_t;

  function automatic logic [9:0] fb_addr(input logic [2:0] page, input logic [6:0] col);
    return {page, col};
  endfunction

endpackage

// File: rtl/fb_ram_sp.sv
// rtl/fb_ram_sp.sv - single-port synchronous-read framebuffer RAM
module fb_ram_sp #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // storage array: written on enabled write cycles, contents never reset
  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= wdata;
  end

  // registered read port; holds the last byte read until the next read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          rdata <= '0;
    else if (en && !we)  rdata <= mem[addr];
  end

endmodule

// File: rtl/fb_arbiter.sv
// rtl/fb_arbiter.sv - framebuffer owner arbitrating SPI reader, game writer and clear sequencer
module fb_arbiter
  import display_pkg::*;
#(
  parameter int                ADDR_W      = 10,
  parameter int                DATA_W      = 8,
  parameter int                COL_BITS    = 7,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = 8'h00
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ADDR_W-COL_BITS-1:0] spi_row,
  input  logic [9:0]                 spi_col,
  output logic [DATA_W-1:0]          spi_data,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       clr_start,
  output logic                       clr_busy,
  output logic                       frame_done
);

  arb_state_t        state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] last_addr;
  logic              last_valid;
  logic [ADDR_W-1:0] prev_addr;
  logic              prev_valid;
  logic              rd_slot;
  logic              clr_wr;
  logic              wr_fire;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              unused_col_hi;

  // upper column bits are outside the 128-column panel
  assign unused_col_hi = ^spi_col[9:COL_BITS];
  assign rd_addr       = fb_addr(spi_row, spi_col[COL_BITS-1:0]);

  // a new reader address claims the RAM for one slot in the following cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_addr  <= '0;
      last_valid <= 1'b0;
      prev_addr  <= '0;
      prev_valid <= 1'b0;
      rd_slot    <= 1'b0;
    end else if (!last_valid || (rd_addr != last_addr)) begin
      prev_addr  <= last_addr;
      prev_valid <= last_valid;
      last_addr  <= rd_addr;
      last_valid <= 1'b1;
      rd_slot    <= 1'b1;
    end else begin
      rd_slot    <= 1'b0;
    end
  end

  // frame pulse lands with the spi_data update of a 1023 -> 0 wrap read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_done <= 1'b0;
    else        frame_done <= rd_slot && (last_addr == '0) && prev_valid && (prev_addr == '1);
  end

  // clear sequencer: walks every address in cycles the reader leaves free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      clr_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_start) begin
            state   <= CLEAR;
            clr_ptr <= '0;
          end
        end
        CLEAR: begin
          if (!rd_slot) begin
            clr_ptr <= clr_ptr + 1'b1;
            if (clr_ptr == '1) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign clr_busy = (state == CLEAR);
  assign clr_wr   = (state == CLEAR) && !rd_slot;
  assign wr_ready = (state == IDLE) && !rd_slot && !clr_start;
  assign wr_fire  = wr_valid && wr_ready;

  // single RAM port: reader first, then clear, then game writer
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = last_addr;
    ram_wdata = wr_data;
    if (rd_slot) begin
      ram_en    = 1'b1;
    end else if (clr_wr) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = clr_ptr;
      ram_wdata = CLEAR_VALUE;
    end else if (wr_fire) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = wr_addr;
    end
  end

  fb_ram_sp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (spi_data)
  );

endmodule
